// File: rtl/divider_unit_pkg.sv
// divider_pkg: shared types and constants for the iterative RV32M divider.
// Holds the FSM state enum, the iteration count, the counter width and an
// absolute-value helper used when preparing signed operands.
package divider_pkg;

  localparam int DATA_W   = 32;
  localparam int DIV_ITER = 32;
  localparam int CNT_W    = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Magnitude of a two's complement value; 0x80000000 maps to 0x80000000.
  function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] neg;
    neg = -v;
    return (v < 0) ? neg : v;
  endfunction

endpackage

// File: rtl/divider_unit_if.sv
// divider_unit_if: request/response bundle between execute stage and divider.
// master = execute stage (issues operations), slave = divider_unit.
interface divider_unit_if;
  import divider_pkg::*;

  logic              start;
  logic [5:0]        alucode;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] divider_result;

  modport master (
    output start, alucode, op1, op2,
    input  busy, done, divider_result
  );

  modport slave (
    input  start, alucode, op1, op2,
    output busy, done, divider_result
  );

endinterface

// File: rtl/divider_unit_step.sv
// divider_step: one combinational restoring division iteration.
// Shifts the next dividend bit into the partial remainder, trial-subtracts the
// divisor and shifts the resulting quotient bit into the quotient register.
module divider_step
  import divider_pkg::*;
(
  input  logic [DATA_W-1:0] rem_in,
  input  logic [DATA_W-1:0] quo_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic [DATA_W-1:0] quo_out
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;
  logic            ge;

  // Trial subtraction; a set carry-out bit of the shifted remainder always fits.
  always_comb begin
    shifted = {rem_in, quo_in[DATA_W-1]};
    diff    = shifted - {1'b0, divisor};
    ge      = shifted[DATA_W] | ~diff[DATA_W];
    rem_out = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    quo_out = {quo_in[DATA_W-2:0], ge};
  end

endmodule

// File: rtl/divider_unit.sv
// divider_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// 32 iterations in CALC, result registered on entry to DONE.
// Optional feature macro: DIVIDER_FASTPATH_EN -- divide-by-zero and signed
// overflow skip the iterations and complete one cycle after acceptance.
`ifndef ALU_DIV
`define ALU_DIV  6'd33
`endif
`ifndef ALU_DIVU
`define ALU_DIVU 6'd34
`endif
`ifndef ALU_REM
`define ALU_REM  6'd35
`endif
`ifndef ALU_REMU
`define ALU_REMU 6'd36
`endif

module divider_unit
  import divider_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  divider_unit_if.slave  dif
);

`ifdef DIVIDER_FASTPATH_EN
  localparam bit FASTPATH = 1'b1;
`else
  localparam bit FASTPATH = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

  div_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             busy_c, done_c;

  // Request decode (p0)
  logic signed [DATA_W-1:0] op1_p0, op2_p0;
  logic is_div_op_p0, is_signed_p0, is_rem_p0;
  logic div0_p0, ovf_p0, accept_p0, fast_p0;

  // Iteration state (p1)
  logic [2*DATA_W-1:0] rq_p1;
  logic [DATA_W-1:0]   divisor_p1, dividend_p1;
  logic                is_rem_p1, div0_p1, ovf_p1, neg_q_p1, neg_r_p1;
  logic [DATA_W-1:0]   rem_nxt, quo_nxt;

  // Registered result (p2)
  logic [DATA_W-1:0]   result_p2;

  // Fixed results for the architecturally defined corner cases.
  function automatic logic [DATA_W-1:0] saturate_special(
    input logic              is_rem,
    input logic              div0,
    input logic [DATA_W-1:0] dividend
  );
    if (div0) return is_rem ? dividend : {DATA_W{1'b1}};
    return is_rem ? '0 : {1'b1, {(DATA_W-1){1'b0}}};
  endfunction

  // Select quotient or remainder and restore the sign of the signed ops.
  function automatic logic [DATA_W-1:0] apply_sign(
    input logic              is_rem,
    input logic              div0,
    input logic              ovf,
    input logic              neg_q,
    input logic              neg_r,
    input logic [DATA_W-1:0] quo,
    input logic [DATA_W-1:0] rem,
    input logic [DATA_W-1:0] dividend
  );
    if (div0 || ovf) return saturate_special(is_rem, div0, dividend);
    if (is_rem) return neg_r ? (~rem + 1'b1) : rem;
    return neg_q ? (~quo + 1'b1) : quo;
  endfunction

  // Decode the incoming request and flag the corner cases.
  always_comb begin
    op1_p0       = dif.op1;
    op2_p0       = dif.op2;
    is_div_op_p0 = (dif.alucode == `ALU_DIV)  || (dif.alucode == `ALU_DIVU) ||
                   (dif.alucode == `ALU_REM)  || (dif.alucode == `ALU_REMU);
    is_signed_p0 = (dif.alucode == `ALU_DIV)  || (dif.alucode == `ALU_REM);
    is_rem_p0    = (dif.alucode == `ALU_REM)  || (dif.alucode == `ALU_REMU);
    div0_p0      = (dif.op2 == '0);
    ovf_p0       = is_signed_p0 && (dif.op1 == {1'b1, {(DATA_W-1){1'b0}}}) &&
                   (dif.op2 == {DATA_W{1'b1}});
    accept_p0    = (state == IDLE) && dif.start && is_div_op_p0;
    fast_p0      = FASTPATH && (div0_p0 || ovf_p0);
  end

  // State register and iteration counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept_p0)
        cnt <= '0;
      else if (state == CALC)
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (accept_p0) state_nxt = fast_p0 ? DONE : CALC;
      end
      CALC: begin
        busy_c = 1'b1;
        if (cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dif.busy           = busy_c;
  assign dif.done           = done_c;
  assign dif.divider_result = result_p2;

  divider_step u_step (
    .rem_in  (rq_p1[2*DATA_W-1:DATA_W]),
    .quo_in  (rq_p1[DATA_W-1:0]),
    .divisor (divisor_p1),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  // ---- p0 -> p1: latch magnitudes and sign fix-ups, then iterate ----
  always_ff @(posedge clk) begin
    if (accept_p0) begin
      rq_p1       <= {{DATA_W{1'b0}}, is_signed_p0 ? abs_val(op1_p0) : dif.op1};
      divisor_p1  <= is_signed_p0 ? abs_val(op2_p0) : dif.op2;
      dividend_p1 <= dif.op1;
      is_rem_p1   <= is_rem_p0;
      div0_p1     <= div0_p0;
      ovf_p1      <= ovf_p0;
      neg_q_p1    <= is_signed_p0 && (op1_p0[DATA_W-1] ^ op2_p0[DATA_W-1]) && !div0_p0;
      neg_r_p1    <= is_signed_p0 && op1_p0[DATA_W-1];
    end else if (state == CALC) begin
      rq_p1 <= {rem_nxt, quo_nxt};
    end
  end

  // ---- p1 -> p2: result register, written only on entry to DONE ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      result_p2 <= '0;
    else if ((state == CALC) && (cnt == CNT_LAST))
      result_p2 <= apply_sign(is_rem_p1, div0_p1, ovf_p1, neg_q_p1, neg_r_p1,
                              quo_nxt, rem_nxt, dividend_p1);
    else if (accept_p0 && fast_p0)
      result_p2 <= saturate_special(is_rem_p0, div0_p0, dif.op1);
  end

endmodule

// File: doc/divider_unit.md
# divider_unit

Iterative radix-2 integer divider for the RV32M DIV/DIVU/REM/REMU operations. It sits in the execute stage beside the combinational multiplier and consumes the same `alucode`/`op1`/`op2` operand bundle from decode. Its 32-bit result feeds the execute result mux that also selects `multipiler_result`. The pipeline stalls on `busy`.

## Interface
Parameters: none. Iteration count is fixed at 32.
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `alucode`  in  6  operation; only `ALU_DIV`, `ALU_DIVU`, `ALU_REM`, `ALU_REMU` (define.vh) are accepted
- `op1`  in  32  dividend
- `op2`  in  32  divisor
- `busy`  out  1  high from the cycle after acceptance until the cycle before `done`
- `done`  out  1  one-cycle pulse; result valid
- `divider_result`  out  32  quotient or remainder, held until the next accepted start

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `start` with a divide alucode latches the op and operands, then goes to CALC.
  - `start` with any other alucode is ignored.
- Signed ops (DIV/REM):
  - Divide absolute values unsigned.
  - Negate the quotient when the operand signs differ and the divisor is nonzero.
  - The remainder takes the sign of the dividend.
  - Unsigned ops use the operands as-is.
- CALC:
  - 32 restoring steps, one per cycle, on a 64-bit {remainder, quotient} shift register.
  - A 6-bit counter runs 0..31. At 31 the block goes to DONE.
- DONE:
  - `done`=1 and `divider_result` is registered with the final value.
  - The next state is IDLE unconditionally.
- Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend. This applies to both signed and unsigned ops.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- `start` during CALC or DONE is ignored. Upstream must hold the request until it sees `done`.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `divider_result`=0, counter 0.
- Reset mid-operation takes effect immediately and asynchronously. The in-flight op is discarded and produces no `done`.
- Normal latency:
  - `start` accepted at the edge ending cycle 0.
  - `busy`=1 in cycles 1..32.
  - `done`=1 with a valid result in cycle 33.
  - Earliest next accept is cycle 34.
- `done` is never high together with `busy`.
- `divider_result` changes only in the DONE cycle and when reset is asserted.

## Configuration
- `DIVIDER_FASTPATH_EN` defined:
  - Divide-by-zero and signed overflow are detected in IDLE and go straight to DONE.
  - `done` comes in cycle 1 and `busy` stays 0.
- Undefined:
  - Every op, including these special cases, runs the full 32 iterations with `done` in cycle 33.
  - The special-case values are still forced at DONE.
- Result values are identical either way; only latency differs.

## Structure
- `divider_pkg` holds:
  - `div_state_t` enum (IDLE, CALC, DONE)
  - `DIV_ITER` = 32
  - the counter width localparam
- Alucode constants stay in define.vh.
- One sub-module: `divider_step`, a single combinational restoring iteration.
  - Inputs: partial remainder, quotient shift, divisor.
  - Outputs: next remainder/quotient.
  - The top instantiates it once per cycle.

## Test plan
- DIVU op1=100, op2=7:
  - `busy` in cycles 1..32, `done` in cycle 33, result 14.
  - REMU with the same operands gives 2.
- DIV op1=0xFFFFFFF9 (−7), op2=2 gives 0xFFFFFFFD. REM gives 0xFFFFFFFF.
- Divide by zero, op1=0x12345678, op2=0:
  - DIV/DIVU give 0xFFFFFFFF; REM/REMU give 0x12345678.
  - `done` in cycle 1 with `DIVIDER_FASTPATH_EN`, cycle 33 without.
- Overflow op1=0x80000000, op2=0xFFFFFFFF: DIV gives 0x80000000, REM gives 0.
- Reset and re-issue:
  - Assert `rst` in cycle 10 of a DIVU; `busy`, `done` and result go to 0 immediately and no `done` appears afterwards.
  - A subsequent DIVU 9/3 gives 3 with normal latency.
- Ignored starts:
  - `start` with `ALU_MUL` produces no `busy` and no `done`.
  - A second `start` during CALC is ignored; only one `done` appears, carrying the first op's result.
